// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between the requesting masters and the shared-resource arbiter.
`timescale 1ns/1ps
interface priority_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             release_i;
  logic             mode;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout_pulse;

  modport master (
    output req, release_i, mode,
    input  grant, grant_idx, grant_valid, timeout_pulse
  );

  modport slave (
    input  req, release_i, mode,
    output grant, grant_idx, grant_valid, timeout_pulse
  );
endinterface

// File: rtl/priority_arbiter.sv
// 8-requester arbiter: fixed or round-robin priority (bit 7 highest), grant held
// until release or holder drop, with a watchdog that force-releases a stuck grant.
`timescale 1ns/1ps
module priority_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  priority_arbiter_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [N-1:0]     grant_r;
  logic [IDX_W-1:0] grant_idx_r;
  logic             grant_valid_r;
  logic             timeout_r;

  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             rel_normal;
  logic             rel_forced;

  // Downward search from start_idx with wrap; fixed mode simply starts at the top bit.
  always_comb begin
    start_idx = bus.mode ? ptr : IDX_W'(N - 1);
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = start_idx - IDX_W'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    rel_normal = bus.release_i || !bus.req[grant_idx_r];
    rel_forced = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IDX_W'(N - 1);
      hold_cnt      <= 8'd0;
      grant_r       <= '0;
      grant_idx_r   <= '0;
      grant_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_r       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            grant_idx_r   <= win_idx;
            grant_valid_r <= 1'b1;
            hold_cnt      <= 8'd0;
            state         <= BUSY;
            if (bus.mode) ptr <= win_idx - IDX_W'(1);
          end
        end
        default: begin
          if (rel_normal || rel_forced) begin
            // grant_idx is left at its last value; only grant_valid qualifies it.
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            timeout_r     <= rel_forced && !rel_normal;
            state         <= IDLE;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.grant         = grant_r;
  assign bus.grant_idx     = grant_idx_r;
  assign bus.grant_valid   = grant_valid_r;
  assign bus.timeout_pulse = timeout_r;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: reset, fixed/round-robin arbitration, watchdog, drops.
`timescale 1ns/1ps
module tb_priority_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  priority_arbiter_if #(.N(8), .IDX_W(3)) bus ();

  priority_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    check_eq({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    check_eq({tag, "_idx"},   32'(bus.grant_idx),   32'(idx));
    check_eq({tag, "_grant"}, 32'(bus.grant),       32'(8'd1 << idx));
  endtask

  task automatic check_idle(input string tag, input logic tp);
    check_eq({tag, "_valid"}, 32'(bus.grant_valid),   32'd0);
    check_eq({tag, "_grant"}, 32'(bus.grant),         32'd0);
    check_eq({tag, "_tp"},    32'(bus.timeout_pulse), 32'(tp));
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = 8'h00;
    bus.release_i = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] rr_seq [9];
    logic [2:0] sparse_seq [3];
    n_checks = 0;
    n_fail   = 0;

    // Reset held with heavy activity
    rst_n         = 1'b0;
    bus.req       = 8'hFF;
    bus.mode      = 1'b1;
    bus.release_i = 1'b0;
    #1;
    tick();
    tick();
    check_idle("rst", 1'b0);
    check_eq("rst_idx", 32'(bus.grant_idx), 32'd0);
    rst_n = 1'b1;
    tick();
    check_grant("rst_first", 3'd7);

    // Fixed priority
    do_reset();
    bus.mode = 1'b0;
    bus.req  = 8'b0100_1111;
    tick();
    check_grant("fix_a", 3'd6);
    bus.release_i = 1'b1;
    tick();
    bus.release_i = 1'b0;
    check_idle("fix_rel", 1'b0);
    check_eq("fix_idx_hold", 32'(bus.grant_idx), 32'd6);
    tick();
    check_grant("fix_b", 3'd6);

    // Round-robin fairness with all requesters active
    do_reset();
    bus.mode = 1'b1;
    bus.req  = 8'hFF;
    rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    for (int i = 0; i < 9; i++) begin
      tick();
      check_grant($sformatf("rr%0d", i), rr_seq[i]);
      tick();
      check_grant($sformatf("rr%0d_hold", i), rr_seq[i]);
      bus.release_i = 1'b1;
      tick();
      bus.release_i = 1'b0;
      check_idle($sformatf("rr%0d_bub", i), 1'b0);
    end

    // Round-robin with sparse requests
    do_reset();
    bus.mode = 1'b1;
    bus.req  = 8'b0000_0101;
    sparse_seq = '{3'd2, 3'd0, 3'd2};
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant($sformatf("sp%0d", i), sparse_seq[i]);
      bus.release_i = 1'b1;
      tick();
      bus.release_i = 1'b0;
      check_idle($sformatf("sp%0d_bub", i), 1'b0);
    end

    // Watchdog: 16 valid cycles, then forced release with a pulse
    do_reset();
    bus.mode = 1'b0;
    bus.req  = 8'b0001_0000;
    tick();
    check_grant("to_c0", 3'd4);
    for (int i = 1; i < 16; i++) begin
      tick();
      check_eq($sformatf("to_c%0d_valid", i), 32'(bus.grant_valid), 32'd1);
      check_eq($sformatf("to_c%0d_tp", i), 32'(bus.timeout_pulse), 32'd0);
    end
    tick();
    check_idle("to_rel", 1'b1);
    tick();
    check_grant("to_regrant", 3'd4);
    check_eq("to_tp_clr", 32'(bus.timeout_pulse), 32'd0);

    // Non-holder activity ignored, then holder drop
    do_reset();
    bus.mode = 1'b0;
    bus.req  = 8'b0000_1000;
    tick();
    check_grant("drop_g", 3'd3);
    bus.req = 8'b1000_1000;
    tick();
    check_grant("drop_keep", 3'd3);
    bus.req = 8'b1000_0000;
    tick();
    check_idle("drop_rel", 1'b0);
    tick();
    check_grant("drop_next", 3'd7);

    // Release coinciding with the watchdog edge is a normal release
    do_reset();
    bus.req = 8'b0000_1000;
    tick();
    check_grant("coin_g", 3'd3);
    for (int i = 1; i < 16; i++) tick();
    check_grant("coin_last", 3'd3);
    bus.release_i = 1'b1;
    tick();
    bus.release_i = 1'b0;
    check_idle("coin_rel", 1'b0);
    tick();
    check_grant("coin_regrant", 3'd3);
    check_eq("coin_tp", 32'(bus.timeout_pulse), 32'd0);

    // Reset in the middle of a grant
    rst_n = 1'b0;
    tick();
    check_idle("midrst", 1'b0);
    check_eq("midrst_idx", 32'(bus.grant_idx), 32'd0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
Name: priority_arbiter

Overview:
- Sequential 8-requester arbiter that shares one downstream resource among eight requesters.
- Uses the same priority-encoding rule as the team's 8-to-3 priority encoder: bit 7 is highest priority, and the result is reported both as a one-hot grant and as a 3-bit index.
- Adds round-robin fairness, grant hold until release, and a watchdog timeout that forces release of a stuck grant.
- Sits between the requesting masters and the shared datapath; `grant_idx` drives the datapath select mux.

Parameters:
- N, 8: number of requesters. This block is fixed at 8; the parameter exists for documentation only.
- IDX_W, 3: index width, log2(N).
- MAX_HOLD, 16: maximum number of cycles a grant may be held. 0 disables the timeout. Legal range is 0..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- req  input  8  request vector; bit i is requester i.
- release_i  input  1  current grant holder finished; valid only while `grant_valid`=1.
- mode  input  1  0 = fixed priority (bit 7 highest); 1 = round-robin.
- grant  output  8  one-hot grant, registered.
- grant_idx  output  3  binary index of the granted requester, registered.
- grant_valid  output  1  a grant is active, registered.
- timeout_pulse  output  1  one-cycle pulse when a grant is force-released, registered.

Behaviour:
- Reset:
  - Any rising edge with rst_n=0 sets `grant`=8'h00, `grant_idx`=3'd0, `grant_valid`=0, `timeout_pulse`=0, `ptr`=3'd7, `hold_cnt`=0, state=IDLE.
  - Reset applies mid-grant with no completion behaviour.
- State machine: two states, IDLE and BUSY.
- IDLE:
  - If |req=0, stay in IDLE; outputs stay 0.
  - If |req=1, select a winner combinationally. At the next edge, register `grant`/`grant_idx`, set `grant_valid`=1, clear `hold_cnt` to 0, go to BUSY.
  - Latency: grant is visible 1 cycle after the request is sampled.
- Winner selection:
  - Fixed mode (`mode`=0): the highest-index asserted bit wins. `ptr` is not updated.
  - Round-robin mode (`mode`=1): search starts at `ptr` and goes downward, wrapping 0 to 7. The first asserted bit wins. On grant, `ptr` <= (winner − 1) mod 8, so the winner becomes the lowest priority.
  - After reset (`ptr`=7), the first round-robin decision matches fixed mode.
  - `mode` is sampled only at the IDLE arbitration edge. Changing it during BUSY does not affect the current grant.
- BUSY:
  - `grant`, `grant_idx` and `grant_valid` are held constant.
  - `hold_cnt` increments every cycle, saturating at 255.
  - Changes on non-holder request bits are ignored.
- Release (leave BUSY). At the edge where any of the following holds, `grant` goes to 0, `grant_valid` to 0, and state to IDLE:
  - a) `release_i`=1;
  - b) `req[grant_idx]`=0 (the holder dropped its request);
  - c) MAX_HOLD≠0 and `hold_cnt`==MAX_HOLD−1 (forced release).
- `grant_idx` after release: holds its last value. It is only meaningful while `grant_valid`=1.
- Timeout pulse:
  - Case c) alone sets `timeout_pulse`=1 for exactly the following cycle.
  - If a) or b) coincides with c), the release is a normal release and `timeout_pulse`=0.
  - A forced release still updates nothing further; `ptr` was already advanced at grant time.
- Mandatory bubble: every release is followed by at least one cycle with `grant_valid`=0. Re-arbitration happens at the next edge. Two grants are never back-to-back without a 0 cycle.
- Without the timeout: with MAX_HOLD=0 a grant is held indefinitely until a) or b).
- Invariants:
  - `grant` is always zero or one-hot.
  - When `grant_valid`=1, `grant`==(1<<`grant_idx`).
  - `grant_valid`=0 implies `grant`=0.

Test Plan:
- Reset with activity: rst_n=0 for 2 cycles, `req`=8'hFF, `mode`=1 → `grant`=8'h00, `grant_valid`=0, `timeout_pulse`=0. Release rst_n → first grant is idx 7, 1 cycle later.
- Fixed priority: `mode`=0, `req`=8'b01001111 → next cycle `grant`=8'b01000000, `grant_idx`=6. Pulse `release_i` → next cycle `grant`=0. With `req` unchanged, the following cycle grants idx 6 again.
- Round-robin fairness: `mode`=1, `req`=8'hFF held, `release_i` pulsed 2 cycles after each grant → `grant_idx` sequence is 7,6,5,4,3,2,1,0,7, each separated by a 1-cycle bubble.
- Round-robin sparse: `mode`=1 from reset, `req`=8'b00000101 → idx 2, then 0, then 2.
- Timeout: MAX_HOLD=16, `req`=8'b00010000, no release → `grant_valid`=1 for exactly 16 cycles with `grant_idx`=4. Then `grant`=0 and `timeout_pulse`=1 for 1 cycle, then re-grant of idx 4.
- Drop and coincident release: with idx 3 granted, deassert `req[3]` → next edge `grant`=0, no timeout pulse. Then MAX_HOLD=16 with `release_i`=1 at `hold_cnt`=15 → release with `timeout_pulse`=0. Also `rst_n`=0 mid-grant → all outputs 0 at that edge.
